// File: rtl/servo_pkg.sv
// Shared constants and types for the servo pulse engine.
// Timing defaults assume a 10 MHz clock divided down to a 1 us tick.
package servo_pkg;

  localparam int BASE_TICKS_DEF  = 1000;
  localparam int STEP_SHIFT_DEF  = 2;
  localparam int FRAME_TICKS_DEF = 20000;
  localparam int TICK_W          = $clog2(FRAME_TICKS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks.
// Held at zero while clr is high so a new frame starts on a clean tick boundary.
module servo_tick_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr || (presc == LAST)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/servo_pulse_gen.sv
// RC-servo frame generator: one pulse of BASE_TICKS + (pos << STEP_SHIFT) ticks
// per FRAME_TICKS-tick frame, with an optional triangle sweep of the position.
module servo_pulse_gen
  import servo_pkg::*;
#(
  parameter int CLK_DIV     = 10,
  parameter int BASE_TICKS  = BASE_TICKS_DEF,
  parameter int STEP_SHIFT  = STEP_SHIFT_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sweep,
  input  logic [7:0] pos,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] cur_pos
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_TICKS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_TICKS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [CNT_W-1:0] width, width_nxt;
  logic [7:0]       cur_pos_nxt;
  logic             dir_down, dir_down_nxt;
  logic             pwm_nxt, fs_nxt;
  logic             tick, presc_clr, start_frame;
  logic [7:0]       sweep_pos, frame_pos;
  logic             sweep_down, frame_down;
  logic [CNT_W-1:0] frame_width;

  assign presc_clr = (state == IDLE);

  servo_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Triangle step with reflection at both ends, so 255 and 0 are each visited once per sweep.
  always_comb begin
    sweep_pos  = cur_pos;
    sweep_down = dir_down;
    if (!dir_down) begin
      if (cur_pos == 8'd255) begin
        sweep_pos  = 8'd254;
        sweep_down = 1'b1;
      end else begin
        sweep_pos = cur_pos + 8'd1;
      end
    end else begin
      if (cur_pos == 8'd0) begin
        sweep_pos  = 8'd1;
        sweep_down = 1'b0;
      end else begin
        sweep_pos = cur_pos - 8'd1;
      end
    end
  end

  assign frame_pos   = sweep ? sweep_pos : pos;
  assign frame_down  = sweep ? sweep_down : dir_down;
  assign frame_width = BASE_C + (CNT_W'(frame_pos) << STEP_SHIFT);

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    width_nxt    = width;
    cur_pos_nxt  = cur_pos;
    dir_down_nxt = dir_down;
    pwm_nxt      = 1'b0;
    fs_nxt       = 1'b0;
    start_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (ena) start_frame = 1'b1;
      end
      PULSE: begin
        if (!ena) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
        end else begin
          pwm_nxt = 1'b1;
          if (tick) begin
            tick_cnt_nxt = tick_cnt + CNT_W'(1);
            if (tick_cnt_nxt == width) begin
              state_nxt = GAP;
              pwm_nxt   = 1'b0;
            end
          end
        end
      end
      GAP: begin
        if (!ena) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
        end else if (tick) begin
          if (tick_cnt == LAST_C) start_frame = 1'b1;
          else tick_cnt_nxt = tick_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        tick_cnt_nxt = '0;
      end
    endcase
    // Position and width are latched only here, so mid-frame input changes cannot glitch a pulse.
    if (start_frame) begin
      state_nxt    = PULSE;
      tick_cnt_nxt = '0;
      pwm_nxt      = 1'b1;
      fs_nxt       = 1'b1;
      cur_pos_nxt  = frame_pos;
      dir_down_nxt = frame_down;
      width_nxt    = frame_width;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      width       <= '0;
      cur_pos     <= 8'd0;
      dir_down    <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_cnt_nxt;
      width       <= width_nxt;
      cur_pos     <= cur_pos_nxt;
      dir_down    <= dir_down_nxt;
      pwm_out     <= pwm_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pulse_gen.sv
// Self-checking bench for servo_pulse_gen with a frame-level reference model
// of pulse widths and the sweep position sequence.
module tb_servo_pulse_gen;

  localparam int CLK_DIV = 2;
  localparam int BASE    = 10;
  localparam int SHIFT   = 0;
  localparam int FRAME   = 300;
  localparam int PERIOD  = FRAME * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       sweep = 1'b0;
  logic [7:0] pos = 8'd0;
  logic       pwm_out, frame_start;
  logic [7:0] cur_pos;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: position of the last frame and sweep direction.
  int m_cur = 0;
  bit m_up  = 1'b1;

  always #5 clk = ~clk;

  servo_pulse_gen #(
    .CLK_DIV    (CLK_DIV),
    .BASE_TICKS (BASE),
    .STEP_SHIFT (SHIFT),
    .FRAME_TICKS(FRAME)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sweep      (sweep),
    .pos        (pos),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .cur_pos    (cur_pos)
  );

  function automatic int model_frame(input int p, input bit sw);
    int nxt;
    if (sw) begin
      nxt = m_cur + (m_up ? 1 : -1);
      if (nxt > 255) begin
        nxt  = 254;
        m_up = 1'b0;
      end else if (nxt < 0) begin
        nxt  = 1;
        m_up = 1'b1;
      end
      m_cur = nxt;
    end else begin
      m_cur = p;
    end
    return m_cur;
  endfunction

  function automatic int exp_high(input int cp);
    return (BASE + (cp << SHIFT)) * CLK_DIV;
  endfunction

  // Called on the negedge where frame_start is high; returns on the next such negedge.
  task automatic measure_frame(input int change_at, input logic [7:0] new_pos, input logic new_sweep,
                               output int high, output int first_low, output int period,
                               output int fs_cnt);
    high = 0; first_low = -1; period = 0; fs_cnt = 0;
    do begin
      if (pwm_out === 1'b1) high++;
      else if (first_low < 0) first_low = period;
      if (frame_start === 1'b1) fs_cnt++;
      period++;
      if (period == change_at) begin
        pos   = new_pos;
        sweep = new_sweep;
      end
      @(negedge clk);
    end while (frame_start !== 1'b1 && period < 3 * PERIOD);
  endtask

  task automatic test_reset();
    int high, first_low, period, fs_cnt, e;
    rst_n = 1'b0; ena = 1'b0; sweep = 1'b0; pos = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %0b want 0", pwm_out); end
    n_tests++;
    if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fs: got %0b want 0", frame_start); end
    n_tests++;
    if (cur_pos !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_cur_pos: got %0d want 0", cur_pos); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_quiet: got pwm=%0b fs=%0b want 0/0", pwm_out, frame_start);
    end
    m_cur = 0; m_up = 1'b1;
    ena = 1'b1;
    @(negedge clk);
    n_tests++;
    if (frame_start !== 1'b1 || pwm_out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL first_frame_start: got fs=%0b pwm=%0b want 1/1", frame_start, pwm_out);
    end
    e = model_frame(pos, sweep);
    measure_frame(7, 8'd255, 1'b0, high, first_low, period, fs_cnt);
    n_tests++;
    if (high != exp_high(e) || first_low != high) begin
      n_fail++; $display("[TB] FAIL pos0_high: got %0d (first low %0d) want %0d", high, first_low, exp_high(e));
    end
    n_tests++;
    if (period != PERIOD) begin n_fail++; $display("[TB] FAIL pos0_period: got %0d want %0d", period, PERIOD); end
    n_tests++;
    if (fs_cnt != 1) begin n_fail++; $display("[TB] FAIL pos0_fs_width: got %0d want 1", fs_cnt); end
  endtask

  task automatic test_full_scale();
    int high, first_low, period, fs_cnt, e;
    e = model_frame(pos, sweep);
    n_tests++;
    if (cur_pos !== 8'd255) begin n_fail++; $display("[TB] FAIL full_cur_pos: got %0d want 255", cur_pos); end
    measure_frame(7, 8'd40, 1'b0, high, first_low, period, fs_cnt);
    n_tests++;
    if (high != exp_high(e)) begin n_fail++; $display("[TB] FAIL full_high: got %0d want %0d", high, exp_high(e)); end
    n_tests++;
    if (period - high != PERIOD - exp_high(e)) begin
      n_fail++; $display("[TB] FAIL full_low: got %0d want %0d", period - high, PERIOD - exp_high(e));
    end
  endtask

  task automatic test_midframe();
    int high, first_low, period, fs_cnt, e;
    e = model_frame(pos, sweep);
    measure_frame(10, 8'd200, 1'b0, high, first_low, period, fs_cnt);
    n_tests++;
    if (high != exp_high(e)) begin n_fail++; $display("[TB] FAIL mid_change_high: got %0d want %0d", high, exp_high(e)); end
    e = model_frame(pos, sweep);
    n_tests++;
    if (cur_pos !== 8'd200) begin n_fail++; $display("[TB] FAIL mid_next_pos: got %0d want 200", cur_pos); end
    measure_frame(7, 8'd253, 1'b0, high, first_low, period, fs_cnt);
    n_tests++;
    if (high != exp_high(e)) begin n_fail++; $display("[TB] FAIL mid_next_high: got %0d want %0d", high, exp_high(e)); end
  endtask

  task automatic test_sweep();
    int high, first_low, period, fs_cnt, e;
    int seq_up[4]   = '{254, 255, 254, 253};
    int seq_down[3] = '{0, 1, 2};
    e = model_frame(pos, sweep);
    n_tests++;
    if (cur_pos !== 8'd253) begin n_fail++; $display("[TB] FAIL sweep_seed: got %0d want 253", cur_pos); end
    measure_frame(3, 8'd253, 1'b1, high, first_low, period, fs_cnt);
    for (int i = 0; i < 4; i++) begin
      e = model_frame(pos, sweep);
      n_tests++;
      if (cur_pos !== seq_up[i][7:0]) begin
        n_fail++; $display("[TB] FAIL sweep_top[%0d]: got %0d want %0d", i, cur_pos, seq_up[i]);
      end
      if (i == 3) measure_frame(3, 8'd1, 1'b0, high, first_low, period, fs_cnt);
      else        measure_frame(0, 8'd0, 1'b1, high, first_low, period, fs_cnt);
      n_tests++;
      if (high != exp_high(seq_up[i])) begin
        n_fail++; $display("[TB] FAIL sweep_top_high[%0d]: got %0d want %0d", i, high, exp_high(seq_up[i]));
      end
    end
    e = model_frame(pos, sweep);
    n_tests++;
    if (cur_pos !== 8'd1) begin n_fail++; $display("[TB] FAIL sweep_manual1: got %0d want 1", cur_pos); end
    measure_frame(3, 8'd1, 1'b1, high, first_low, period, fs_cnt);
    for (int i = 0; i < 3; i++) begin
      e = model_frame(pos, sweep);
      n_tests++;
      if (cur_pos !== seq_down[i][7:0]) begin
        n_fail++; $display("[TB] FAIL sweep_bottom[%0d]: got %0d want %0d", i, cur_pos, seq_down[i]);
      end
      if (i == 2) measure_frame(3, 8'd90, 1'b0, high, first_low, period, fs_cnt);
      else        measure_frame(0, 8'd0, 1'b1, high, first_low, period, fs_cnt);
    end
  endtask

  task automatic test_random();
    int high, first_low, period, fs_cnt, e, chg;
    logic [7:0] npos;
    logic nsw;
    for (int i = 0; i < 12; i++) begin
      e    = model_frame(pos, sweep);
      chg  = $urandom_range(1, PERIOD - 10);
      npos = 8'($urandom_range(0, 255));
      nsw  = (i == 11) ? 1'b0 : ($urandom_range(0, 2) == 0);
      n_tests++;
      if (cur_pos !== 8'(e)) begin n_fail++; $display("[TB] FAIL rand_cur_pos[%0d]: got %0d want %0d", i, cur_pos, e); end
      measure_frame(chg, npos, nsw, high, first_low, period, fs_cnt);
      n_tests++;
      if (high != exp_high(e) || first_low != high) begin
        n_fail++; $display("[TB] FAIL rand_high[%0d]: got %0d (first low %0d) want %0d", i, high, first_low, exp_high(e));
      end
      n_tests++;
      if (period != PERIOD || fs_cnt != 1) begin
        n_fail++; $display("[TB] FAIL rand_frame[%0d]: got period %0d fs %0d want %0d/1", i, period, fs_cnt, PERIOD);
      end
    end
  endtask

  task automatic test_ena_drop();
    int high, first_low, period, fs_cnt, e;
    e = model_frame(pos, sweep);
    repeat ($urandom_range(2, 15)) @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_pre_pwm: got %0b want 1", pwm_out); end
    ena = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_pwm: got %0b want 0", pwm_out); end
    repeat (5) @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b0 || frame_start !== 1'b0 || cur_pos !== 8'(e)) begin
      n_fail++; $display("[TB] FAIL drop_idle: got pwm=%0b fs=%0b pos=%0d want 0/0/%0d", pwm_out, frame_start, cur_pos, e);
    end
    pos = 8'd77; sweep = 1'b0; ena = 1'b1;
    @(negedge clk);
    n_tests++;
    if (frame_start !== 1'b1) begin n_fail++; $display("[TB] FAIL rearm_fs: got %0b want 1", frame_start); end
    e = model_frame(pos, sweep);
    measure_frame(5, 8'd5, 1'b0, high, first_low, period, fs_cnt);
    n_tests++;
    if (high != exp_high(e) || period != PERIOD) begin
      n_fail++; $display("[TB] FAIL rearm_frame: got high %0d period %0d want %0d/%0d", high, period, exp_high(e), PERIOD);
    end
  endtask

  task automatic test_reset_gap();
    int high, first_low, period, fs_cnt, e;
    e = model_frame(pos, sweep);
    repeat (60) @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b0 || cur_pos !== 8'(e)) begin
      n_fail++; $display("[TB] FAIL gap_pre: got pwm=%0b pos=%0d want 0/%0d", pwm_out, cur_pos, e);
    end
    pos = 8'd123;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 1'b0 || frame_start !== 1'b0 || cur_pos !== 8'd0) begin
      n_fail++; $display("[TB] FAIL gap_async_reset: got pwm=%0b fs=%0b pos=%0d want 0/0/0", pwm_out, frame_start, cur_pos);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = 0; m_up = 1'b1;
    @(negedge clk);
    n_tests++;
    if (frame_start !== 1'b1 || cur_pos !== 8'd123) begin
      n_fail++; $display("[TB] FAIL gap_restart: got fs=%0b pos=%0d want 1/123", frame_start, cur_pos);
    end
    e = model_frame(pos, sweep);
    measure_frame(5, 8'd60, 1'b0, high, first_low, period, fs_cnt);
    n_tests++;
    if (high != exp_high(e) || period != PERIOD) begin
      n_fail++; $display("[TB] FAIL gap_restart_frame: got high %0d period %0d want %0d/%0d", high, period, exp_high(e), PERIOD);
    end
  endtask

  task automatic test_reset_pulse();
    int e;
    e = model_frame(pos, sweep);
    repeat (4) @(negedge clk);
    n_tests++;
    if (pwm_out !== 1'b1 || cur_pos !== 8'(e)) begin
      n_fail++; $display("[TB] FAIL pulse_pre: got pwm=%0b pos=%0d want 1/%0d", pwm_out, cur_pos, e);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 1'b0) begin n_fail++; $display("[TB] FAIL pulse_async_reset: got %0b want 0", pwm_out); end
    @(negedge clk);
    ena = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_midframe();
    test_sweep();
    test_random();
    test_ena_drop();
    test_reset_gap();
    test_reset_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
